// File: rtl/joystick_conditioner.sv
// Button conditioner: synchronise, debounce, per-frame snapshot, press/release/auto-repeat pulses.
// Optional auto-repeat is built only when JOY_AUTOREPEAT_EN is defined; otherwise btn_repeat is zero.
module joystick_conditioner #(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vsync,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_frame,
    output logic               frame_strobe,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        (64'(DEBOUNCE_CYCLES - 1) >> CNT_W) != 64'd0) begin : g_param_check
        $error("joystick_conditioner: illegal parameter combination");
    end

    logic [NUM_BTN-1:0] raw_meta_q, raw_sync_q;
    logic               vs_meta_q, vs_sync_q, vs_prev_q;
    logic               vs_rise;

    // Two-flop synchronisers plus vsync edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_meta_q <= '0;
            raw_sync_q <= '0;
            vs_meta_q  <= 1'b0;
            vs_sync_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
        end else begin
            raw_meta_q <= btn_raw;
            raw_sync_q <= raw_meta_q;
            vs_meta_q  <= vsync;
            vs_sync_q  <= vs_meta_q;
            vs_prev_q  <= vs_sync_q;
        end
    end

    assign vs_rise = vs_sync_q & ~vs_prev_q;

    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] frame_q, press_q, release_q;
    logic               strobe_q;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (raw_sync_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = raw_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            frame_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
            strobe_q  <= vs_rise;
            // Snapshot takes the pre-update level when both change on one edge
            if (vs_rise) begin
                frame_q <= level_q;
            end
        end
    end

    assign btn_level    = level_q;
    assign btn_frame    = frame_q;
    assign frame_strobe = strobe_q;
    assign btn_press    = press_q;
    assign btn_release  = release_q;

`ifdef JOY_AUTOREPEAT_EN
    localparam int unsigned FCNT_W = 8;
    localparam logic [FCNT_W-1:0] DELAY_LAST = FCNT_W'(REPEAT_DELAY - 1);
    localparam logic [FCNT_W-1:0] RATE_LAST  = FCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    rpt_state_e         state_q [NUM_BTN];
    rpt_state_e         state_d [NUM_BTN];
    logic [FCNT_W-1:0]  fcnt_q  [NUM_BTN];
    logic [FCNT_W-1:0]  fcnt_d  [NUM_BTN];
    logic [NUM_BTN-1:0] repeat_q, repeat_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= RPT_IDLE;
                fcnt_q[i]  <= '0;
            end
            repeat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                fcnt_q[i]  <= fcnt_d[i];
            end
            repeat_q <= repeat_d;
        end
    end

    // Release (next level low) wins over a coincident frame edge
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            fcnt_d[i]  = fcnt_q[i];
            if (!level_d[i]) begin
                state_d[i] = RPT_IDLE;
                fcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (!level_q[i]) begin
                            state_d[i] = RPT_DELAY;
                            fcnt_d[i]  = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (vs_rise) begin
                            if (fcnt_q[i] == DELAY_LAST) begin
                                repeat_d[i] = 1'b1;
                                state_d[i]  = RPT_REPEAT;
                                fcnt_d[i]   = '0;
                            end else begin
                                fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
                            end
                        end
                    end
                    RPT_REPEAT: begin
                        if (vs_rise) begin
                            if (fcnt_q[i] == RATE_LAST) begin
                                repeat_d[i] = 1'b1;
                                fcnt_d[i]   = '0;
                            end else begin
                                fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                        fcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_joystick_conditioner.sv
// Self-checking bench for joystick_conditioner: directed scenarios plus a cycle-level behavioural model.
module tb_joystick_conditioner;

    localparam int unsigned NB = 3;
    localparam int unsigned DC = 8;
    localparam int unsigned RD = 4;
    localparam int unsigned RR = 2;
    localparam int unsigned CW = 4;
    localparam int          HN = 4096;

`ifdef JOY_AUTOREPEAT_EN
    localparam logic [31:0] EXP_REP_MASK = 32'h0000_0550;
`else
    localparam logic [31:0] EXP_REP_MASK = 32'h0000_0000;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          vsync   = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_frame, btn_press, btn_release, btn_repeat;
    logic          frame_strobe;

    joystick_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(CW),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_frame(btn_frame), .frame_strobe(frame_strobe),
        .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: history of sampled inputs, outputs derived from window rules
    logic [NB-1:0] raw_h [HN];
    logic          vs_h  [HN];
    int            n = 0;
    logic [NB-1:0] m_level = '0, m_frame = '0, m_press = '0, m_release = '0, m_repeat = '0;
    logic          m_strobe = 1'b0;
    int            m_k   [NB];
    bit            m_act [NB];

    function automatic logic [NB-1:0] raw_at(input int j);
        return (j >= 1 && j < HN) ? raw_h[j] : '0;
    endfunction

    function automatic logic vs_at(input int j);
        return (j >= 1 && j < HN) ? vs_h[j] : 1'b0;
    endfunction

    initial begin : model
        logic [NB-1:0] smp;
        bit flip, vsr, old_v, new_v;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                n = 0;
                m_level = '0; m_frame = '0; m_press = '0; m_release = '0;
                m_repeat = '0; m_strobe = 1'b0;
                for (int i = 0; i < NB; i++) begin
                    m_k[i] = 0;
                    m_act[i] = 1'b0;
                end
            end else begin
                n++;
                if (n >= HN) begin
                    $display("FAIL model_history: edge %0d exceeds history depth %0d", n, HN);
                    $fatal(1, "history overflow");
                end
                raw_h[n] = btn_raw;
                vs_h[n]  = vsync;
                vsr = vs_at(n - 2) && !vs_at(n - 3);
                m_strobe = vsr;
                if (vsr) m_frame = m_level;
                m_repeat = '0;
                for (int i = 0; i < NB; i++) begin
                    old_v = m_level[i];
                    flip  = 1'b1;
                    for (int j = n - 1 - int'(DC); j <= n - 2; j++) begin
                        smp = raw_at(j);
                        if (smp[i] == old_v) flip = 1'b0;
                    end
                    new_v = flip ? !old_v : old_v;
                    m_press[i]   = flip && new_v;
                    m_release[i] = flip && !new_v;
                    m_level[i]   = new_v;
`ifdef JOY_AUTOREPEAT_EN
                    if (!new_v) begin
                        m_act[i] = 1'b0;
                        m_k[i]   = 0;
                    end else if (flip) begin
                        m_act[i] = 1'b1;
                        m_k[i]   = 0;
                    end else if (m_act[i] && vsr) begin
                        m_k[i]++;
                        if (m_k[i] >= int'(RD) && (m_k[i] - int'(RD)) % int'(RR) == 0)
                            m_repeat[i] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("model_level",   32'(btn_level),    32'(m_level));
            chk("model_frame",   32'(btn_frame),    32'(m_frame));
            chk("model_strobe",  32'(frame_strobe), 32'(m_strobe));
            chk("model_press",   32'(btn_press),    32'(m_press));
            chk("model_release", 32'(btn_release),  32'(m_release));
            chk("model_repeat",  32'(btn_repeat),   32'(m_repeat));
        end
    end

    // Directed-scenario event counters
    int          s_strobes;
    int          s_press [NB];
    int          s_rel   [NB];
    int          s_rep_cnt;
    logic [31:0] s_rep_mask;

    task automatic clear_counts();
        s_strobes = 0; s_rep_cnt = 0; s_rep_mask = '0;
        for (int i = 0; i < NB; i++) begin
            s_press[i] = 0;
            s_rel[i] = 0;
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            if (frame_strobe) s_strobes++;
            for (int i = 0; i < NB; i++) begin
                if (btn_press[i])   s_press[i]++;
                if (btn_release[i]) s_rel[i]++;
            end
            if (btn_repeat[0]) begin
                s_rep_cnt++;
                if (s_strobes < 32) s_rep_mask[s_strobes] = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic frame();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        cyc(8);
    endtask

    initial begin : stim
        clear_counts();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({btn_level, btn_frame, btn_press, btn_release, btn_repeat, frame_strobe}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press on channel 0
        clear_counts();
        btn_raw[0] = 1'b1;
        cyc(9);
        chk("s1_level_edge9", 32'(btn_level), 32'd0);
        cyc(1);
        chk("s1_level_edge10", 32'(btn_level), 32'b001);
        chk("s1_press_edge10", 32'(btn_press), 32'b001);
        cyc(1);
        chk("s1_press_edge11", 32'(btn_press), 32'd0);
        chk("s1_other_events", 32'(s_press[1] + s_press[2] + s_rel[0] + s_rel[1] + s_rel[2]), 32'd0);

        // Hold channel 0 across ten frames
        clear_counts();
        repeat (10) frame();
        chk("s4_strobes", 32'(s_strobes), 32'd10);
        chk("s4_repeat_mask", s_rep_mask, EXP_REP_MASK);

        // Release landing on the edge of a due repeat
        frame();
        clear_counts();
        btn_raw[0] = 1'b0;
        cyc(7);
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        cyc(8);
        chk("s5_release_cnt", 32'(s_rel[0]), 32'd1);
        chk("s5_repeat_cnt", 32'(s_rep_cnt), 32'd0);
        chk("s5_strobes", 32'(s_strobes), 32'd1);
        chk("s5_level", 32'(btn_level), 32'd0);

        // Bouncing channel 1
        clear_counts();
        for (int t = 0; t < 10; t++) begin
            btn_raw[1] = ~btn_raw[1];
            cyc(3);
        end
        chk("s2_bounce_events", 32'(s_press[1] + s_rel[1]), 32'd0);
        btn_raw[1] = 1'b1;
        cyc(9);
        chk("s2_level_edge9", 32'(btn_level[1]), 32'd0);
        cyc(1);
        chk("s2_level_edge10", 32'(btn_level[1]), 32'd1);
        chk("s2_press_cnt", 32'(s_press[1]), 32'd1);

        // Mid-frame press on channel 2, snapshot waits for vsync
        btn_raw[2] = 1'b1;
        cyc(12);
        chk("s3_level", 32'(btn_level), 32'b110);
        chk("s3_frame_before", 32'(btn_frame[2]), 32'd0);
        cyc(5);
        chk("s3_frame_hold", 32'(btn_frame[2]), 32'd0);
        clear_counts();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        chk("s3_frame_edge2", 32'(btn_frame[2]), 32'd0);
        chk("s3_no_strobe_yet", 32'(s_strobes), 32'd0);
        cyc(1);
        chk("s3_frame_edge3", 32'(btn_frame), 32'b110);
        chk("s3_strobe_edge3", 32'(frame_strobe), 32'd1);
        cyc(1);
        chk("s3_strobe_edge4", 32'(frame_strobe), 32'd0);
        chk("s3_strobe_cnt", 32'(s_strobes), 32'd1);

        // Asynchronous reset mid-debounce
        btn_raw = 3'b111;
        cyc(5);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("s6_async_reset", 32'({btn_level, btn_frame, btn_press, btn_release, btn_repeat, frame_strobe}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_counts();
        cyc(9);
        chk("s6_level_edge9", 32'(btn_level), 32'd0);
        cyc(1);
        chk("s6_level_edge10", 32'(btn_level), 32'b111);
        chk("s6_press_edge10", 32'(btn_press), 32'b111);
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/joystick_conditioner.md
Name: joystick_conditioner

Overview:
Input-conditioning stage directly upstream of tank_controller. It turns raw, bouncy, asynchronous board buttons (left/right/up) into synchronised, debounced levels. It also produces a per-frame snapshot that holds steady for a whole video frame, plus press, release and auto-repeat pulses. tank_controller's switch_left/right/up inputs connect to btn_frame; menu and fire logic use the pulses.

Parameters:
NUM_BTN, 3, number of independent button channels
DEBOUNCE_CYCLES, 250000, stable clk cycles required before a level change is accepted (10 ms at 25 MHz); minimum 1
CNT_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES-1
REPEAT_DELAY, 16, frames from press to first repeat pulse; minimum 1
REPEAT_RATE, 4, frames between subsequent repeat pulses; minimum 1

Ports:
clk  in  1  pixel clock (25 MHz domain)
reset_n  in  1  asynchronous, active-low reset
vsync  in  1  frame sync from hvsync_generator; rising edge marks a frame
btn_raw  in  NUM_BTN  raw buttons, active-high, asynchronous
btn_level  out  NUM_BTN  debounced level
btn_frame  out  NUM_BTN  btn_level sampled at each vsync rising edge
frame_strobe  out  1  one-clk pulse in the cycle btn_frame updates
btn_press  out  NUM_BTN  one-clk pulse when btn_level goes 0->1
btn_release  out  NUM_BTN  one-clk pulse when btn_level goes 1->0
btn_repeat  out  NUM_BTN  one-clk auto-repeat pulse

Behaviour:
- Reset (async assert, sync release): all outputs, synchroniser flops, counters and repeat FSMs go to 0/IDLE.
- Synchronisers: 2-flop synchroniser on each btn_raw bit and on vsync.
  - vs_rise = sync_vsync & ~previous sync_vsync.
- Debounce, per channel, using counter cnt:
  - If sync == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any reversion to the old value before acceptance clears cnt.
- Debounce latency: a clean raw change is visible on btn_level at the (2+DEBOUNCE_CYCLES)th rising clk edge after the change.
- btn_press/btn_release: registered, asserted in exactly the cycle btn_level changes. Never both high on the same channel.
- Frame snapshot:
  - On the edge following vs_rise detection, btn_frame <= btn_level (pre-update value if btn_level changes on that same edge).
  - frame_strobe is high for that one cycle.
  - btn_frame latency: 3 edges after the raw vsync rise.
- Auto-repeat FSM, per channel (states IDLE, DELAY, REPEAT; frame counter fcnt, 8 bits):
  - IDLE: on btn_press -> DELAY, fcnt <= 0.
  - DELAY: on vs_rise, fcnt++. At the vs_rise with fcnt == REPEAT_DELAY-1, pulse btn_repeat, go to REPEAT, fcnt <= 0.
  - REPEAT: on vs_rise, fcnt++. At fcnt == REPEAT_RATE-1, pulse btn_repeat, fcnt <= 0.
  - Any state: btn_level == 0 -> IDLE, fcnt <= 0. Release has priority over a simultaneous vs_rise, so no repeat pulse is emitted then.
  - btn_repeat pulses coincide with frame_strobe.
- A press arriving on the same edge as vs_rise enters DELAY. That vs_rise is not counted.
- Channels are fully independent; simultaneous events on several channels are all honoured.
- DEBOUNCE_CYCLES = 1: a change is accepted one edge after the synchronised change.

Optional Feature:
JOY_AUTOREPEAT_EN:
- Defined: auto-repeat FSMs and frame counters are built as described.
- Undefined: no repeat logic is synthesised, and btn_repeat is tied to all zeros. All other outputs are unchanged.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, REPEAT_DELAY=4, REPEAT_RATE=2, NUM_BTN=3.
1. btn_raw[0] steps 0->1 and is held -> btn_level[0] rises at the 10th edge; one btn_press[0] pulse at that edge; btn_release and channels 1-2 stay 0.
2. btn_raw[1] toggles every 3 cycles for 30 cycles, then holds 1 -> no pulse during bounce; exactly one btn_press[1] pulse, 10 edges after the last toggle.
3. btn_level[2] rises mid-frame -> btn_frame[2] stays 0 until the next vsync; it becomes 1 3 edges after the vsync raw rise, with frame_strobe high that cycle only.
4. Button 0 is held across 10 vsync pulses (JOY_AUTOREPEAT_EN defined) -> btn_repeat[0] pulses at the 4th, 6th, 8th and 10th vs_rise after the press.
5. Button 0 is released so that btn_level falls on the same edge as a due repeat vs_rise -> no btn_repeat; one btn_release pulse; FSM returns to IDLE.
6. reset_n is asserted mid-debounce with btn_level=1 -> all outputs are 0 immediately, without a clock. After release with raw held 1, btn_level rises at the 10th edge with a btn_press pulse. With JOY_AUTOREPEAT_EN undefined, scenario 4 gives btn_repeat = 0 throughout.
